// File: rtl/gigatron_spi_pkg.sv
// Shared definitions for the Gigatron SPI target.
//   CMD_READ_BIT    : command bit that selects a register read burst
//   ID_BYTE_DEFAULT : byte returned on MISO while the command byte is clocked in
//   spi_state_e     : transaction state of the target
package gigatron_spi_pkg;

  localparam int unsigned CMD_READ_BIT    = 7;
  localparam logic [7:0]  ID_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [1:0] {
    StIdle,
    StCmd,
    StWr,
    StRd
  } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for an asynchronous SPI pin, with an optional third
// flop that turns the synchronised level into single-cycle edge pulses.
//   clk_i  : local oversampling clock
//   rst_i  : asynchronous active-high reset
//   d_i    : asynchronous pin
//   q_o    : synchronised level (2 CLK lag)
//   rise_o : one-CLK pulse on a synchronised 0->1 transition (0 if EdgeDetect=0)
//   fall_o : one-CLK pulse on a synchronised 1->0 transition (0 if EdgeDetect=0)
module spi_sync_edge #(
  parameter bit EdgeDetect = 1'b1,
  parameter bit ResetVal   = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= {2{ResetVal}};
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  assign q_o = sync_q[1];

  if (EdgeDetect) begin : g_edge
    logic edge_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        edge_q <= ResetVal;
      end else begin
        edge_q <= sync_q[1];
      end
    end

    assign rise_o = sync_q[1] & ~edge_q;
    assign fall_o = ~sync_q[1] & edge_q;
  end else begin : g_level_only
    assign rise_o = 1'b0;
    assign fall_o = 1'b0;
  end

endmodule

// File: rtl/gigatron_spi_target.sv
// SPI target (CPHA=0) for the bit-banged master of the Gigatron extension
// CPLD. Exposes a 2**NREGS_LOG2 byte register file over SPI and over a
// parallel host port.
//
// SPI protocol: byte 0 is the command (bit 7 = read, low bits = start
// address) while ID_BYTE is returned; following bytes are written to, or read
// from, consecutive addresses (wrapping).
//
// Ports:
//   clk_i, rst_i          : local clock (>= 8x SCK toggle rate), async reset
//   sck_i, mosi_i, nss_i  : asynchronous SPI pins from the master
//   miso_o, miso_oe_o     : serial data to master, output enable while selected
//   host_addr_i           : host register address
//   host_we_i             : host write strobe (one CLK)
//   host_wdata_i          : host write data
//   host_rdata_o          : regs[host_addr_i], combinational
//   spi_wstb_o            : one-CLK pulse when an SPI write commits
//   spi_waddr_o           : address of the last committed SPI write
module gigatron_spi_target
  import gigatron_spi_pkg::*;
#(
  parameter bit          CPOL       = 1'b0,
  parameter logic [7:0]  ID_BYTE    = ID_BYTE_DEFAULT,
  parameter int unsigned NREGS_LOG2 = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  sck_i,
  input  logic                  mosi_i,
  input  logic                  nss_i,
  output logic                  miso_o,
  output logic                  miso_oe_o,
  input  logic [NREGS_LOG2-1:0] host_addr_i,
  input  logic                  host_we_i,
  input  logic [7:0]            host_wdata_i,
  output logic [7:0]            host_rdata_o,
  output logic                  spi_wstb_o,
  output logic [NREGS_LOG2-1:0] spi_waddr_o
);

  localparam int unsigned NRegs = 2 ** NREGS_LOG2;

  // ---------------------------------------------------------------------------
  // Pin synchronisation
  // ---------------------------------------------------------------------------
  logic sck_s, sck_rise, sck_fall;
  logic nss_s, nss_rise, nss_fall;
  logic mosi_s, mosi_rise, mosi_fall;

  spi_sync_edge #(
    .EdgeDetect(1'b1),
    .ResetVal  (CPOL)
  ) u_sync_sck (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (sck_i),
    .q_o   (sck_s),
    .rise_o(sck_rise),
    .fall_o(sck_fall)
  );

  // nSS resets to 0 so that a master still holding nSS low across a reset does
  // not produce a fresh falling edge: the target stays idle until re-selected.
  spi_sync_edge #(
    .EdgeDetect(1'b1),
    .ResetVal  (1'b0)
  ) u_sync_nss (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (nss_i),
    .q_o   (nss_s),
    .rise_o(nss_rise),
    .fall_o(nss_fall)
  );

  spi_sync_edge #(
    .EdgeDetect(1'b0),
    .ResetVal  (1'b0)
  ) u_sync_mosi (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (mosi_i),
    .q_o   (mosi_s),
    .rise_o(mosi_rise),
    .fall_o(mosi_fall)
  );

  logic unused_sync;
  assign unused_sync = ^{sck_s, mosi_rise, mosi_fall};

  // Leading edge samples, trailing edge shifts.
  logic sample_edge, shift_edge;
  assign sample_edge = CPOL ? sck_fall : sck_rise;
  assign shift_edge  = CPOL ? sck_rise : sck_fall;

  // ---------------------------------------------------------------------------
  // Transaction state
  // ---------------------------------------------------------------------------
  spi_state_e            state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [6:0]            rx_q, rx_d;
  logic [7:0]            tx_q, tx_d;
  logic [NREGS_LOG2-1:0] addr_q, addr_d;
  logic                  oe_q, oe_d;
  logic                  wstb_q, wstb_d;
  logic [NREGS_LOG2-1:0] waddr_q, waddr_d;
  logic [7:0]            regs_q [NRegs];

  logic [7:0]            byte_next;
  logic                  spi_we;

  // The byte as it stands after the current sample edge.
  assign byte_next = {rx_q, mosi_s};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rx_d    = rx_q;
    tx_d    = tx_q;
    addr_d  = addr_q;
    oe_d    = oe_q;
    wstb_d  = 1'b0;
    waddr_d = waddr_q;
    spi_we  = 1'b0;

    if (nss_rise) begin
      // Deselect drops any partial byte.
      state_d = StIdle;
      oe_d    = 1'b0;
      tx_d    = 8'h00;
      cnt_d   = 3'd0;
    end else if (nss_fall) begin
      state_d = StCmd;
      tx_d    = ID_BYTE;
      cnt_d   = 3'd0;
      oe_d    = 1'b1;
    end else if ((state_q != StIdle) && !nss_s) begin
      if (sample_edge) begin
        rx_d  = byte_next[6:0];
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          unique case (state_q)
            StCmd: begin
              state_d = byte_next[CMD_READ_BIT] ? StRd : StWr;
              addr_d  = byte_next[NREGS_LOG2-1:0];
            end
            StWr: begin
              spi_we  = 1'b1;
              wstb_d  = 1'b1;
              waddr_d = addr_q;
              addr_d  = addr_q + NREGS_LOG2'(1);
            end
            StRd: begin
              addr_d = addr_q + NREGS_LOG2'(1);
            end
            default: ;
          endcase
        end
      end else if (shift_edge) begin
        if (cnt_q == 3'd0) begin
          // Byte boundary: addr_q already points at the next read address.
          tx_d = (state_q == StRd) ? regs_q[addr_q] : 8'h00;
        end else begin
          tx_d = {tx_q[6:0], 1'b0};
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= 3'd0;
      rx_q    <= 7'd0;
      tx_q    <= 8'h00;
      addr_q  <= '0;
      oe_q    <= 1'b0;
      wstb_q  <= 1'b0;
      waddr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rx_q    <= rx_d;
      tx_q    <= tx_d;
      addr_q  <= addr_d;
      oe_q    <= oe_d;
      wstb_q  <= wstb_d;
      waddr_q <= waddr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Register file: an SPI commit beats a host write to the same address.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(NRegs); i++) begin
        regs_q[i] <= 8'h00;
      end
    end else begin
      if (host_we_i && !(spi_we && (host_addr_i == addr_q))) begin
        regs_q[host_addr_i] <= host_wdata_i;
      end
      if (spi_we) begin
        regs_q[addr_q] <= byte_next;
      end
    end
  end

  assign host_rdata_o = regs_q[host_addr_i];
  assign miso_o       = tx_q[7];
  assign miso_oe_o    = oe_q;
  assign spi_wstb_o   = wstb_q;
  assign spi_waddr_o  = waddr_q;

endmodule

// File: tb/tb_gigatron_spi_target.sv
// Bench for gigatron_spi_target: a CPOL=0 and a CPOL=1 instance receive the
// same SPI traffic (SCK of the second is the inverse of the first) and are
// checked against a register-array model of the command protocol.
module tb_gigatron_spi_target;

  localparam logic [7:0] Id   = 8'hA5;
  localparam int         Half = 8;  // CLKs per SCK half period

  logic       clk = 1'b0;
  logic       rst0, rst1;
  logic       phase;  // 1 = SCK away from its idle level
  logic       mosi, nss;
  logic [3:0] host_addr;
  logic       host_we;
  logic [7:0] host_wdata;

  logic       miso0, oe0, wstb0, miso1, oe1, wstb1;
  logic [7:0] rdata0, rdata1;
  logic [3:0] waddr0, waddr1;

  always #5 clk = ~clk;

  gigatron_spi_target #(.CPOL(1'b0), .ID_BYTE(Id), .NREGS_LOG2(4)) u_dut0 (
    .clk_i(clk), .rst_i(rst0), .sck_i(phase), .mosi_i(mosi), .nss_i(nss),
    .miso_o(miso0), .miso_oe_o(oe0), .host_addr_i(host_addr), .host_we_i(host_we),
    .host_wdata_i(host_wdata), .host_rdata_o(rdata0), .spi_wstb_o(wstb0),
    .spi_waddr_o(waddr0)
  );

  gigatron_spi_target #(.CPOL(1'b1), .ID_BYTE(Id), .NREGS_LOG2(4)) u_dut1 (
    .clk_i(clk), .rst_i(rst1), .sck_i(~phase), .mosi_i(mosi), .nss_i(nss),
    .miso_o(miso1), .miso_oe_o(oe1), .host_addr_i(host_addr), .host_we_i(host_we),
    .host_wdata_i(host_wdata), .host_rdata_o(rdata1), .spi_wstb_o(wstb1),
    .spi_waddr_o(waddr1)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] m [16];     // model register file
  logic [3:0] ewq [$];    // expected strobe addresses
  logic [3:0] wq0 [$];
  logic [3:0] wq1 [$];
  logic [7:0] xbuf [8];

  always @(negedge clk) begin
    if (wstb0) wq0.push_back(waddr0);
    if (wstb1) wq1.push_back(waddr1);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic host_write(input logic [3:0] a, input logic [7:0] d);
    host_addr  = a;
    host_wdata = d;
    host_we    = 1'b1;
    wait_clks(1);
    host_we = 1'b0;
    m[a]    = d;
  endtask

  task automatic read_reg(input logic [3:0] a);
    host_addr = a;
    wait_clks(1);
    check_eq($sformatf("rdata0[%0d]", a), rdata0, m[a]);
    check_eq($sformatf("rdata1[%0d]", a), rdata1, m[a]);
  endtask

  task automatic select_dut();
    nss = 1'b0;
    wait_clks(Half);
  endtask

  task automatic deselect_dut();
    nss = 1'b1;
    wait_clks(Half);
  endtask

  // Clock nbits of tx MSB first; MISO is captured just before each sample
  // edge. Optionally fire a host write in the CLK the last sample commits.
  task automatic spi_bits(input logic [7:0] tx, input int nbits, input bit hw_en,
                          input logic [3:0] hw_addr, input logic [7:0] hw_data,
                          output logic [7:0] r0, output logic [7:0] r1);
    r0 = 8'h00;
    r1 = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      mosi = tx[7-i];
      wait_clks(Half);
      r0[7-i] = miso0;
      r1[7-i] = miso1;
      phase   = 1'b1;
      if (hw_en && (i == nbits - 1)) begin
        wait_clks(2);
        host_addr  = hw_addr;
        host_wdata = hw_data;
        host_we    = 1'b1;
        wait_clks(1);
        host_we = 1'b0;
        wait_clks(Half - 3);
      end else begin
        wait_clks(Half);
      end
      phase = 1'b0;
    end
    wait_clks(Half);
  endtask

  task automatic check_strobes(input string tag);
    check_eq({tag, " wstb0 count"}, wq0.size(), ewq.size());
    check_eq({tag, " wstb1 count"}, wq1.size(), ewq.size());
    for (int i = 0; i < ewq.size(); i++) begin
      if (i < wq0.size()) check_eq($sformatf("%s waddr0[%0d]", tag, i), wq0[i], ewq[i]);
      if (i < wq1.size()) check_eq($sformatf("%s waddr1[%0d]", tag, i), wq1[i], ewq[i]);
    end
    ewq.delete();
    wq0.delete();
    wq1.delete();
  endtask

  // Full transaction from xbuf[0..nbytes-1], optional trailing partial byte.
  task automatic run_xfer(input string tag, input int nbytes, input int pbits,
                          input logic [7:0] pval);
    logic [7:0] r0, r1, e;
    logic [3:0] a;
    bit         rd;
    select_dut();
    check_eq({tag, " oe0 sel"}, oe0, 1'b1);
    check_eq({tag, " oe1 sel"}, oe1, 1'b1);
    a  = xbuf[0][3:0];
    rd = xbuf[0][7];
    for (int k = 0; k < nbytes; k++) begin
      e = (k == 0) ? Id : (rd ? m[a] : 8'h00);
      spi_bits(xbuf[k], 8, 1'b0, 4'd0, 8'h00, r0, r1);
      check_eq($sformatf("%s miso0 b%0d", tag, k), r0, e);
      check_eq($sformatf("%s miso1 b%0d", tag, k), r1, e);
      if (k > 0) begin
        if (!rd) begin
          m[a] = xbuf[k];
          ewq.push_back(a);
        end
        a++;
      end
    end
    if (pbits > 0) spi_bits(pval, pbits, 1'b0, 4'd0, 8'h00, r0, r1);
    deselect_dut();
    check_eq({tag, " oe0 desel"}, oe0, 1'b0);
    check_eq({tag, " oe1 desel"}, oe1, 1'b0);
    check_eq({tag, " miso0 desel"}, miso0, 1'b0);
    check_eq({tag, " miso1 desel"}, miso1, 1'b0);
    check_strobes(tag);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    n_errors++;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] r0, r1;
    int         nb;
    int         pb;

    for (int i = 0; i < 16; i++) m[i] = 8'h00;
    rst0 = 1'b1; rst1 = 1'b1; phase = 1'b0; mosi = 1'b0; nss = 1'b1;
    host_addr = 4'd7; host_we = 1'b0; host_wdata = 8'h00;
    wait_clks(4);
    check_eq("reset miso0", miso0, 1'b0);
    check_eq("reset oe0", oe0, 1'b0);
    check_eq("reset wstb0", wstb0, 1'b0);
    check_eq("reset waddr0", waddr0, 4'd0);
    check_eq("reset rdata0", rdata0, 8'h00);
    check_eq("reset miso1", miso1, 1'b0);
    check_eq("reset oe1", oe1, 1'b0);
    check_eq("reset rdata1", rdata1, 8'h00);
    rst0 = 1'b0; rst1 = 1'b0;
    wait_clks(4);

    // ID byte on a bare write command
    xbuf[0] = 8'h03;
    run_xfer("id", 1, 0, 8'h00);

    // Write burst wrapping 15 -> 0
    xbuf[0] = 8'h0E; xbuf[1] = 8'h11; xbuf[2] = 8'h22; xbuf[3] = 8'h33;
    run_xfer("wburst", 4, 0, 8'h00);
    read_reg(4'd14); read_reg(4'd15); read_reg(4'd0);

    // Read burst of host-written data
    host_write(4'd5, 8'hC3);
    host_write(4'd6, 8'h3C);
    xbuf[0] = 8'h85; xbuf[1] = 8'h00; xbuf[2] = 8'hFF;
    run_xfer("rburst", 3, 0, 8'h00);

    // Partial data byte is discarded
    xbuf[0] = 8'h02;
    run_xfer("partial", 1, 5, 8'hB7);
    read_reg(4'd2);

    // Host/SPI collisions: same address (SPI wins), different address (both)
    select_dut();
    spi_bits(8'h04, 8, 1'b0, 4'd0, 8'h00, r0, r1);
    check_eq("coll cmd miso0", r0, Id);
    spi_bits(8'h5A, 8, 1'b1, 4'd4, 8'hFF, r0, r1);
    m[4] = 8'h5A; ewq.push_back(4'd4);
    spi_bits(8'h77, 8, 1'b1, 4'd9, 8'hAA, r0, r1);
    m[5] = 8'h77; m[9] = 8'hAA; ewq.push_back(4'd5);
    deselect_dut();
    check_strobes("coll");
    read_reg(4'd4); read_reg(4'd5); read_reg(4'd9);

    // Randomised traffic
    for (int t = 0; t < 24; t++) begin
      if ($urandom_range(0, 1) == 1)
        host_write(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
      nb = 1 + $urandom_range(0, 3);
      xbuf[0] = 8'($urandom_range(0, 255));
      for (int k = 1; k < nb; k++) xbuf[k] = 8'($urandom_range(0, 255));
      pb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      run_xfer($sformatf("rnd%0d", t), nb, pb, 8'($urandom_range(0, 255)));
    end
    for (int i = 0; i < 16; i++) read_reg(4'(i));

    // Async reset of the CPOL=1 instance mid-byte
    host_write(4'd4, 8'h5A);
    select_dut();
    spi_bits(8'h83, 8, 1'b0, 4'd0, 8'h00, r0, r1);
    check_eq("rst cmd miso0", r0, Id);
    check_eq("rst cmd miso1", r1, Id);
    spi_bits(8'h00, 4, 1'b0, 4'd0, 8'h00, r0, r1);
    host_addr = 4'd4;
    rst1 = 1'b1;
    #1;
    check_eq("rst miso1", miso1, 1'b0);
    check_eq("rst oe1", oe1, 1'b0);
    check_eq("rst rdata1", rdata1, 8'h00);
    check_eq("rst wstb1", wstb1, 1'b0);
    wait_clks(2);
    rst1 = 1'b0;
    spi_bits(8'h00, 4, 1'b0, 4'd0, 8'h00, r0, r1);
    check_eq("post-rst ignored miso1", r1, 8'h00);
    check_eq("post-rst oe1", oe1, 1'b0);
    check_eq("post-rst oe0", oe0, 1'b1);
    deselect_dut();
    select_dut();
    check_eq("resel oe1", oe1, 1'b1);
    spi_bits(8'h03, 8, 1'b0, 4'd0, 8'h00, r0, r1);
    check_eq("resel miso0", r0, Id);
    check_eq("resel miso1", r1, Id);
    deselect_dut();
    check_strobes("rst");
    check_eq("rst keeps dut0 reg", rdata0, 8'h5A);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
